// File: rtl/des_pkg.sv
// DES constants: permutation tables, S-boxes, key rotation schedule, FSM encoding
// and the bit-permutation helpers shared by the core and the round module.
package des_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned HALF_W  = 32;
  localparam int unsigned KEY_W   = 56;
  localparam int unsigned CD_W    = 28;
  localparam int unsigned SUBK_W  = 48;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Tables use DES 1-based bit numbering; DES bit n of a W-bit word is vector bit W-n.
  localparam byte unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam byte unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam byte unsigned E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam byte unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam byte unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam byte unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Each box is 64 nibbles, entry (row*16+col) at the most significant end first.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  localparam logic [1:0] ENC_ROT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  localparam logic [1:0] DEC_ROT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [BLOCK_W-1:0] perm_ip(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - int'(IP_TAB[6'(i)]))];
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] perm_fp(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - int'(FP_TAB[6'(i)]))];
    return y;
  endfunction

  function automatic logic [SUBK_W-1:0] perm_e(input logic [HALF_W-1:0] x);
    logic [SUBK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - int'(E_TAB[6'(i)]))];
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] perm_p(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - int'(P_TAB[5'(i)]))];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] perm_pc1(input logic [BLOCK_W-1:0] x);
    logic [KEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - int'(PC1_TAB[6'(i)]))];
    return y;
  endfunction

  function automatic logic [SUBK_W-1:0] perm_pc2(input logic [KEY_W-1:0] x);
    logic [SUBK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - int'(PC2_TAB[6'(i)]))];
    return y;
  endfunction

  // Row is the outer bit pair of each 6-bit group, column the inner four bits.
  function automatic logic [HALF_W-1:0] sbox_sub(input logic [SUBK_W-1:0] x);
    logic [HALF_W-1:0] y;
    logic [5:0]        b;
    logic [5:0]        ent;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      b   = x[6'(47 - 6 * j) -: 6];
      ent = {b[5], b[0], b[4:1]};
      y[5'(31 - 4 * j) -: 4] = SBOX[3'(j)][8'(255 - 4 * int'(ent)) -: 4];
    end
    return y;
  endfunction

  function automatic logic [CD_W-1:0] rot28(input logic [CD_W-1:0] x, input logic [1:0] n,
                                            input logic right);
    logic [CD_W-1:0] y;
    case ({right, n})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// One DES Feistel round together with its key-schedule rotation step.
module des_round
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] l_in,
  input  logic [HALF_W-1:0] r_in,
  input  logic [CD_W-1:0]   c_in,
  input  logic [CD_W-1:0]   d_in,
  input  logic [CNT_W-1:0]  round_idx,
  input  logic              decrypt,
  output logic [HALF_W-1:0] l_out_c,
  output logic [HALF_W-1:0] r_out_c,
  output logic [CD_W-1:0]   c_out_c,
  output logic [CD_W-1:0]   d_out_c
);

  logic [1:0]        rot_amt;
  logic [SUBK_W-1:0] subkey;

  // Decrypt walks the schedule backwards by rotating right from K16.
  always_comb begin
    rot_amt = decrypt ? DEC_ROT[round_idx] : ENC_ROT[round_idx];
    c_out_c = rot28(c_in, rot_amt, decrypt);
    d_out_c = rot28(d_in, rot_amt, decrypt);
    subkey  = perm_pc2({c_out_c, d_out_c});
    l_out_c = r_in;
    r_out_c = l_in ^ perm_p(sbox_sub(perm_e(r_in) ^ subkey));
  end

endmodule

// File: rtl/des_iterative_core.sv
// Iterative DES engine: IDLE/RUN/DONE control around a chain of
// ROUNDS_PER_CYCLE Feistel rounds, with IP/PC-1 on load and swap/FP on completion.
module des_iterative_core
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_decrypt,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  if ((ROUNDS_PER_CYCLE != 1) && (ROUNDS_PER_CYCLE != 2) && (ROUNDS_PER_CYCLE != 4) &&
      (ROUNDS_PER_CYCLE != 8) && (ROUNDS_PER_CYCLE != 16)) begin : g_bad_rpc
    $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]         state_q, state_d;
  logic [HALF_W-1:0]  l_q, l_d, r_q, r_d;
  logic [CD_W-1:0]    c_q, c_d, d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dec_q, dec_d;
  logic [BLOCK_W-1:0] out_block_q, out_block_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W:0]     cnt_sum;

  logic [HALF_W-1:0]  l_ch [0:ROUNDS_PER_CYCLE];
  logic [HALF_W-1:0]  r_ch [0:ROUNDS_PER_CYCLE];
  logic [CD_W-1:0]    c_ch [0:ROUNDS_PER_CYCLE];
  logic [CD_W-1:0]    d_ch [0:ROUNDS_PER_CYCLE];

  assign l_ch[0] = l_q;
  assign r_ch[0] = r_q;
  assign c_ch[0] = c_q;
  assign d_ch[0] = d_q;

  // Each stage uses the absolute round number so the rotation schedule is cycle-independent.
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    des_round u_round (
      .l_in      (l_ch[g]),
      .r_in      (r_ch[g]),
      .c_in      (c_ch[g]),
      .d_in      (d_ch[g]),
      .round_idx (cnt_q + CNT_W'(g)),
      .decrypt   (dec_q),
      .l_out_c   (l_ch[g+1]),
      .r_out_c   (r_ch[g+1]),
      .c_out_c   (c_ch[g+1]),
      .d_out_c   (d_ch[g+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    out_block_d = out_block_q;
    cnt_sum     = {1'b0, cnt_q} + (CNT_W + 1)'(ROUNDS_PER_CYCLE);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = perm_ip(in_block);
          {c_d, d_d} = perm_pc1(in_key);
          dec_d      = in_decrypt;
          cnt_d      = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        l_d   = l_ch[ROUNDS_PER_CYCLE];
        r_d   = r_ch[ROUNDS_PER_CYCLE];
        c_d   = c_ch[ROUNDS_PER_CYCLE];
        d_d   = d_ch[ROUNDS_PER_CYCLE];
        cnt_d = cnt_sum[CNT_W-1:0];
        // Carry out of the counter marks round 16 completing this cycle.
        if (cnt_sum[CNT_W]) begin
          out_block_d = perm_fp({r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]});
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      out_block_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      out_block_q <= out_block_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_block = out_block_q;

endmodule

// File: tb/tb_des_iterative_core.sv
// Directed bench for des_iterative_core, one instance per legal ROUNDS_PER_CYCLE
// (index i runs with 2**i rounds per clock).
`timescale 1ns/1ps
module tb_des_iterative_core;

  localparam int NI = 5;
  localparam int LAT_TAB [NI] = '{16, 8, 4, 2, 1};

  localparam logic [63:0] KEY1 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] KEY1_PAR = 64'h1235_5678_9ABD_DEF0;
  localparam logic [63:0] PT1  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT1  = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] KEY2 = 64'h0E32_9232_EA6D_0D73;
  localparam logic [63:0] PT2  = 64'h8787_8787_8787_8787;
  localparam logic [63:0] CT2  = 64'h0000_0000_0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
  logic              in_decrypt;
  logic [63:0]       in_block, in_key;
  logic [63:0]       out_block_v [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_iterative_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid_v[g]),
      .in_ready   (in_ready_v[g]),
      .in_decrypt (in_decrypt),
      .in_block   (in_block),
      .in_key     (in_key),
      .out_valid  (out_valid_v[g]),
      .out_ready  (out_ready_v[g]),
      .out_block  (out_block_v[g]),
      .busy       (busy_v[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on instance idx; hold = cycles of out_ready back-pressure,
  // poke = keep in_valid high with junk inputs during RUN and DONE.
  task automatic do_op(input int idx, input logic dec, input logic [63:0] blk,
                       input logic [63:0] key, input logic [63:0] exp_blk,
                       input int exp_lat, input int hold, input bit poke, input string tag);
    int cyc;
    chk({tag, "_ready_idle"}, 64'(in_ready_v[idx]), 64'd1);
    in_decrypt = dec;
    in_block = blk;
    in_key = key;
    in_valid_v[idx] = 1'b1;
    tick();
    in_valid_v[idx] = 1'b0;
    cyc = 0;
    while (!out_valid_v[idx] && cyc < 40) begin
      chk({tag, "_ready_run"}, 64'(in_ready_v[idx]), 64'd0);
      chk({tag, "_busy_run"}, 64'(busy_v[idx]), 64'd1);
      if (poke) begin
        in_valid_v[idx] = 1'b1;
        in_block = ~blk;
        in_key = ~key;
        in_decrypt = ~dec;
      end
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_block"}, out_block_v[idx], exp_blk);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(out_valid_v[idx]), 64'd1);
      chk({tag, "_hold_block"}, out_block_v[idx], exp_blk);
      chk({tag, "_hold_ready"}, 64'(in_ready_v[idx]), 64'd0);
    end
    in_valid_v[idx] = 1'b0;
    out_ready_v[idx] = 1'b1;
    tick();
    out_ready_v[idx] = 1'b0;
    chk({tag, "_ready_after"}, 64'(in_ready_v[idx]), 64'd1);
    chk({tag, "_valid_after"}, 64'(out_valid_v[idx]), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy_v[idx]), 64'd0);
    chk({tag, "_block_kept"}, out_block_v[idx], exp_blk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    in_decrypt = 1'b0;
    in_block = '0;
    in_key = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ready_%0d", i), 64'(in_ready_v[i]), 64'd1);
      chk($sformatf("rst_valid_%0d", i), 64'(out_valid_v[i]), 64'd0);
      chk($sformatf("rst_busy_%0d", i), 64'(busy_v[i]), 64'd0);
      chk($sformatf("rst_block_%0d", i), out_block_v[i], 64'h0);
    end
    rst_n = 1'b1;
    tick();

    do_op(0, 1'b0, PT1, KEY1, CT1, 16, 0, 1'b0, "enc1_r1");
    do_op(0, 1'b1, CT1, KEY1, PT1, 16, 0, 1'b0, "dec1_r1");
    do_op(0, 1'b0, PT2, KEY2, CT2, 16, 0, 1'b0, "enc2_r1");
    do_op(2, 1'b1, CT2, KEY2, PT2, 4, 0, 1'b0, "dec2_r4");

    for (int i = 1; i < NI; i++) begin
      do_op(i, 1'b0, PT1, KEY1, CT1, LAT_TAB[i], 0, 1'b0, $sformatf("enc1_i%0d", i));
      do_op(i, 1'b1, CT1, KEY1, PT1, LAT_TAB[i], 0, 1'b0, $sformatf("dec1_i%0d", i));
    end

    do_op(0, 1'b0, PT1, KEY1, CT1, 16, 10, 1'b1, "bp_r1");
    do_op(3, 1'b1, CT1, KEY1, PT1, 2, 10, 1'b1, "bp_r8");

    // Abort after seven rounds, then confirm a clean restart.
    in_decrypt = 1'b0;
    in_block = PT1;
    in_key = KEY1;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    repeat (7) tick();
    chk("mid_busy", 64'(busy_v[0]), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_ready", 64'(in_ready_v[0]), 64'd1);
    chk("abort_valid", 64'(out_valid_v[0]), 64'd0);
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_block", out_block_v[0], 64'h0);
    rst_n = 1'b1;
    tick();
    do_op(0, 1'b0, PT1, KEY1, CT1, 16, 0, 1'b0, "post_abort");

    do_op(0, 1'b0, PT1, KEY1_PAR, CT1, 16, 0, 1'b0, "parity_r1");
    do_op(4, 1'b0, PT1, KEY1_PAR, CT1, 1, 0, 1'b0, "parity_r16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_iterative_core.md
# des_iterative_core

Iterative DES encrypt/decrypt engine built around the Feistel round function, generalised to evaluate a parametrised number of rounds per clock. It accepts one 64-bit block and one 64-bit key over a valid/ready handshake and returns the 64-bit result. Internally it performs the initial permutation, 16 Feistel rounds with an on-the-fly key schedule (PC-1, rotations, PC-2), the final swap and the final permutation. It is the block-level cipher engine that system wrappers instantiate.

## Interface
- ROUNDS_PER_CYCLE, 1, number of Feistel rounds evaluated combinationally per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  request present.
- in_ready  output  1  core can accept a request.
- in_decrypt  input  1  0 = encrypt, 1 = decrypt. Sampled on handshake.
- in_block  input  64  plaintext or ciphertext; bit 63 = DES bit 1.
- in_key  input  64  DES key including parity bits; parity bits are ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_block  output  64  result; bit 63 = DES bit 1.
- busy  output  1  high in RUN or DONE.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load L/R from IP(in_block), C/D from PC-1(in_key), and the mode bit; clear the round counter; go to RUN.
- RUN: each cycle applies ROUNDS_PER_CYCLE chained rounds. For each round:
  - Rotate C/D.
  - K = PC-2(C,D).
  - L' = R; R' = L ^ f(R, K), where f is expansion, XOR with K, S1–S8, then P.
  - The round counter (4 bits) advances by ROUNDS_PER_CYCLE.
  - When the counter reaches 16, wrapping to 0, the result is registered and the state moves to DONE.
- Key rotation schedule:
  - Encrypt, rounds 1–16, rotate left by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, rounds 1–16, rotate right by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - The schedule is indexed by the absolute round number, not the cycle number.
- Result: out_block = FP(R16 ‖ L16), i.e. the halves are swapped before FP. It is registered on the RUN→DONE transition.
- DONE:
  - out_valid = 1; out_block is held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so there is no overlapped accept.
- out_block keeps its last value after leaving DONE. It is only meaningful while out_valid is high.
- Inputs are not sampled outside the IDLE handshake. Changes to in_* during RUN or DONE have no effect.
- Reset, including assertion mid-RUN or mid-DONE, aborts the operation. The core returns to IDLE with no result produced.

## Timing
- Reset values:
  - in_ready = 1 (IDLE).
  - out_valid = 0, busy = 0, out_block = 64'h0.
  - Internal L, R, C, D, counter and mode all 0.
- Latency from the accepting clock edge to out_valid high is N = 16/ROUNDS_PER_CYCLE cycles (1 → 16, 2 → 8, 4 → 4, 8 → 2, 16 → 1).
- in_ready returns high on the cycle after the out_valid & out_ready handshake.
- Throughput is one block per N+2 cycles when out_ready is held high.
- in_ready and out_valid are pure decodes of the state register. No combinational path runs from in_valid or out_ready to any output.
- Critical path is ROUNDS_PER_CYCLE × (f function + key step). Timing closure for values above 2 is the integrator's concern.

## Structure
- Package des_pkg holds:
  - IP, FP, E, P, PC-1 and PC-2 permutation index constants.
  - S-box tables S1–S8.
  - Encrypt and decrypt rotation-amount arrays.
  - The state enum type (IDLE/RUN/DONE).
- Sub-module des_round: one Feistel round plus one key-schedule step.
  - Inputs: L, R, C, D, round index, mode. Outputs: L', R', C', D'.
  - The core instantiates it ROUNDS_PER_CYCLE times in a generate chain.
- The core contains only the FSM, the counter, the state registers, IP/PC-1 on load, and swap/FP on completion.

## Test plan
- Encrypt, ROUNDS_PER_CYCLE=1: key 133457799BBCDFF1, block 0123456789ABCDEF → out_block 85E813540F0AB405, out_valid exactly 16 cycles after accept.
- Decrypt of that result with the same key → 0123456789ABCDEF. Also key 0E329232EA6D0D73, block 8787878787878787, encrypt → 0000000000000000.
- Parameter sweep 2/4/8/16 using the first vector: same ciphertext, latency 8/4/2/1 cycles, in_ready low throughout RUN and DONE.
- Back-pressure: out_ready held 0 for 10 cycles → out_valid and out_block stable; out_ready pulse → in_ready high the following cycle. in_valid asserted during RUN is ignored.
- Reset mid-RUN at round 7 → next cycle in_ready=1, out_valid=0, busy=0. A subsequent request produces the correct ciphertext.
- Parity independence: flip all eight parity bits of the key (bits 56,48,…,0) → identical ciphertext.
